// File: rtl/wb_stage.sv
// Write-back stage: accepts retiring instructions from MEM, waits for the
// load response when needed, and commits to the register file, the ID
// bypass port and the debug trace.
module wb_stage #(
    parameter int unsigned REG_W  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // MEM -> WB handshake and payload
    input  logic              ms_valid_i,
    output logic              ws_allowin_o,
    input  logic [REG_W-1:0]  ms_pc_i,
    input  logic              ms_gr_we_i,
    input  logic [ADDR_W-1:0] ms_dest_i,
    input  logic [REG_W-1:0]  ms_alu_result_i,
    input  logic [2:0]        ms_load_op_i,
    // data-SRAM read response
    input  logic              data_rvalid_i,
    input  logic [REG_W-1:0]  data_rdata_i,
    // register-file write port
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [REG_W-1:0]  rf_wdata_o,
    // ID-stage bypass
    output logic              ws_fwd_valid_o,
    output logic              ws_fwd_ok_o,
    output logic [ADDR_W-1:0] ws_fwd_dest_o,
    output logic [REG_W-1:0]  ws_fwd_data_o,
    // debug trace
    output logic [REG_W-1:0]  debug_wb_pc_o,
    output logic [3:0]        debug_wb_rf_we_o,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum_o,
    output logic [REG_W-1:0]  debug_wb_rf_wdata_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_B    = 3'b001;
    localparam logic [2:0] OP_H    = 3'b010;
    localparam logic [2:0] OP_BU   = 3'b101;
    localparam logic [2:0] OP_HU   = 3'b110;

    state_t            state_q;
    logic [REG_W-1:0]  pc_q;
    logic              gr_we_q;
    logic [ADDR_W-1:0] dest_q;
    logic [REG_W-1:0]  alu_q;
    logic [2:0]        load_op_q;
    logic [REG_W-1:0]  ld_buf_q;

    logic              accept;
    logic              writes_gpr;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [REG_W-1:0]  final_data;

    assign ws_allowin_o = (state_q != S_WAIT);
    assign accept       = ms_valid_i && ws_allowin_o;
    assign writes_gpr   = gr_we_q && (dest_q != ADDR_W'(0));

    // State machine and latched instruction fields; rvalid only matters in WAIT
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_EMPTY;
            pc_q      <= '0;
            gr_we_q   <= 1'b0;
            dest_q    <= '0;
            alu_q     <= '0;
            load_op_q <= '0;
            ld_buf_q  <= '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (data_rvalid_i) begin
                        ld_buf_q <= data_rdata_i;
                        state_q  <= S_READY;
                    end
                end
                default: begin
                    if (accept) begin
                        pc_q      <= ms_pc_i;
                        gr_we_q   <= ms_gr_we_i;
                        dest_q    <= ms_dest_i;
                        alu_q     <= ms_alu_result_i;
                        load_op_q <= ms_load_op_i;
                        state_q   <= (ms_load_op_i == OP_NONE) ? S_READY : S_WAIT;
                    end else begin
                        state_q   <= S_EMPTY;
                    end
                end
            endcase
        end
    end

    // Byte/half lane selection from the load address offset; off[0] ignored for halves
    always_comb begin
        ld_byte = 8'h00;
        case (alu_q[1:0])
            2'd0:    ld_byte = ld_buf_q[7:0];
            2'd1:    ld_byte = ld_buf_q[15:8];
            2'd2:    ld_byte = ld_buf_q[23:16];
            default: ld_byte = ld_buf_q[31:24];
        endcase
        ld_half = alu_q[1] ? ld_buf_q[31:16] : ld_buf_q[15:0];
    end

    // Final write-back value; undefined load codes fall through to a full word
    always_comb begin
        final_data = ld_buf_q;
        case (load_op_q)
            OP_NONE: final_data = alu_q;
            OP_B:    final_data = {{24{ld_byte[7]}}, ld_byte};
            OP_BU:   final_data = {24'h000000, ld_byte};
            OP_H:    final_data = {{16{ld_half[15]}}, ld_half};
            OP_HU:   final_data = {16'h0000, ld_half};
            default: final_data = ld_buf_q;
        endcase
    end

    // Commit, bypass and trace decode; everything reads zero while EMPTY
    always_comb begin
        rf_we_o             = 1'b0;
        rf_waddr_o          = '0;
        rf_wdata_o          = '0;
        ws_fwd_valid_o      = 1'b0;
        ws_fwd_ok_o         = 1'b0;
        ws_fwd_dest_o       = '0;
        ws_fwd_data_o       = '0;
        debug_wb_pc_o       = '0;
        if (state_q != S_EMPTY) begin
            ws_fwd_valid_o = writes_gpr;
            ws_fwd_dest_o  = dest_q;
        end
        if (state_q == S_READY) begin
            rf_we_o       = writes_gpr;
            rf_waddr_o    = dest_q;
            rf_wdata_o    = final_data;
            ws_fwd_ok_o   = writes_gpr;
            ws_fwd_data_o = final_data;
            debug_wb_pc_o = pc_q;
        end
        debug_wb_rf_we_o    = {4{rf_we_o}};
        debug_wb_rf_wnum_o  = rf_waddr_o;
        debug_wb_rf_wdata_o = rf_wdata_o;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected commits, a
// negedge monitor pops and compares whenever the stage presents a commit.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ms_valid_i = 1'b0;
    logic        ws_allowin_o;
    logic [31:0] ms_pc_i = '0;
    logic        ms_gr_we_i = 1'b0;
    logic [4:0]  ms_dest_i = '0;
    logic [31:0] ms_alu_result_i = '0;
    logic [2:0]  ms_load_op_i = '0;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        ws_fwd_valid_o;
    logic        ws_fwd_ok_o;
    logic [4:0]  ws_fwd_dest_o;
    logic [31:0] ws_fwd_data_o;
    logic [31:0] debug_wb_pc_o;
    logic [3:0]  debug_wb_rf_we_o;
    logic [4:0]  debug_wb_rf_wnum_o;
    logic [31:0] debug_wb_rf_wdata_o;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk_i = ~clk_i;

    wb_stage dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .ms_valid_i         (ms_valid_i),
        .ws_allowin_o       (ws_allowin_o),
        .ms_pc_i            (ms_pc_i),
        .ms_gr_we_i         (ms_gr_we_i),
        .ms_dest_i          (ms_dest_i),
        .ms_alu_result_i    (ms_alu_result_i),
        .ms_load_op_i       (ms_load_op_i),
        .data_rvalid_i      (data_rvalid_i),
        .data_rdata_i       (data_rdata_i),
        .rf_we_o            (rf_we_o),
        .rf_waddr_o         (rf_waddr_o),
        .rf_wdata_o         (rf_wdata_o),
        .ws_fwd_valid_o     (ws_fwd_valid_o),
        .ws_fwd_ok_o        (ws_fwd_ok_o),
        .ws_fwd_dest_o      (ws_fwd_dest_o),
        .ws_fwd_data_o      (ws_fwd_data_o),
        .debug_wb_pc_o      (debug_wb_pc_o),
        .debug_wb_rf_we_o   (debug_wb_rf_we_o),
        .debug_wb_rf_wnum_o (debug_wb_rf_wnum_o),
        .debug_wb_rf_wdata_o(debug_wb_rf_wdata_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: any commit cycle must match the oldest expected commit
    always @(negedge clk_i) begin
        if (rst_ni && (debug_wb_pc_o != 32'h0 || rf_we_o)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit_pc", debug_wb_pc_o, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_pc",      debug_wb_pc_o, e.pc);
                chk("rf_we",          32'(rf_we_o), 32'(e.we));
                chk("rf_waddr",       32'(rf_waddr_o), 32'(e.waddr));
                chk("rf_wdata",       rf_wdata_o, e.wdata);
                chk("dbg_we",         32'(debug_wb_rf_we_o), e.we ? 32'hF : 32'h0);
                chk("dbg_wnum",       32'(debug_wb_rf_wnum_o), 32'(e.waddr));
                chk("dbg_wdata",      debug_wb_rf_wdata_o, e.wdata);
                chk("fwd_valid",      32'(ws_fwd_valid_o), 32'(e.we));
                chk("fwd_ok",         32'(ws_fwd_ok_o), 32'(e.we));
                chk("allowin_ready",  32'(ws_allowin_o), 32'h1);
                if (e.we) begin
                    chk("fwd_dest", 32'(ws_fwd_dest_o), 32'(e.waddr));
                    chk("fwd_data", ws_fwd_data_o, e.wdata);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                                input logic [31:0] data);
        exp_t e;
        e.pc    = pc;
        e.we    = we && (dest != 5'd0);
        e.waddr = dest;
        e.wdata = data;
        return e;
    endfunction

    task automatic drive_ms(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                            input logic [31:0] alu, input logic [2:0] op);
        ms_valid_i      = 1'b1;
        ms_pc_i         = pc;
        ms_gr_we_i      = we;
        ms_dest_i       = dest;
        ms_alu_result_i = alu;
        ms_load_op_i    = op;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_check(input string name);
        @(negedge clk_i);
        chk({name, "_allowin"},   32'(ws_allowin_o), 32'h1);
        chk({name, "_rf_we"},     32'(rf_we_o), 32'h0);
        chk({name, "_fwd_valid"}, 32'(ws_fwd_valid_o), 32'h0);
        chk({name, "_dbg_pc"},    debug_wb_pc_o, 32'h0);
        chk({name, "_wdata"},     rf_wdata_o, 32'h0);
    endtask

    // Issue a load; a junk rvalid in the accept cycle must be ignored.
    // Response arrives so it is sampled 'delay' edges after accept.
    task automatic do_load(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                           input logic [31:0] addr, input logic [2:0] op,
                           input logic [31:0] rdata, input int delay, input logic [31:0] expd);
        exp_q.push_back(mk(pc, we, dest, expd));
        drive_ms(pc, we, dest, addr, op);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hDEAD_BEEF;
        tick();
        ms_valid_i    = 1'b0;
        data_rvalid_i = 1'b0;
        for (int i = 0; i < delay; i++) begin
            if (i == delay - 1) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = rdata;
            end
            @(negedge clk_i);
            chk("wait_allowin",   32'(ws_allowin_o), 32'h0);
            chk("wait_fwd_valid", 32'(ws_fwd_valid_o), 32'((we && dest != 5'd0) ? 1 : 0));
            chk("wait_fwd_ok",    32'(ws_fwd_ok_o), 32'h0);
            chk("wait_rf_we",     32'(rf_we_o), 32'h0);
            tick();
        end
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        tick();
    endtask

    initial begin
        // reset held, then released with no traffic
        #2;
        idle_check("in_reset");
        rst_ni = 1'b1;
        tick();
        idle_check("post_reset");
        tick();
        idle_check("post_reset2");

        // back-to-back non-loads, allowin stays high
        exp_q.push_back(mk(32'h0000_1000, 1'b1, 5'd3, 32'h11));
        drive_ms(32'h0000_1000, 1'b1, 5'd3, 32'h11, 3'b000);
        tick();
        exp_q.push_back(mk(32'h0000_1004, 1'b1, 5'd5, 32'h22));
        drive_ms(32'h0000_1004, 1'b1, 5'd5, 32'h22, 3'b000);
        tick();
        ms_valid_i = 1'b0;
        tick();
        idle_check("after_b2b");

        // byte loads from offset 2 of 0x12803456, response 3 edges after accept
        do_load(32'h0000_2000, 1'b1, 5'd7, 32'h0000_8002, 3'b001, 32'h1280_3456, 3, 32'hFFFF_FF80);
        do_load(32'h0000_2004, 1'b1, 5'd8, 32'h0000_8002, 3'b101, 32'h1280_3456, 3, 32'h0000_0080);
        // halves and words on 0x80017FFF
        do_load(32'h0000_2008, 1'b1, 5'd9,  32'h0000_8002, 3'b010, 32'h8001_7FFF, 1, 32'hFFFF_8001);
        do_load(32'h0000_200C, 1'b1, 5'd10, 32'h0000_8002, 3'b110, 32'h8001_7FFF, 2, 32'h0000_8001);
        do_load(32'h0000_2010, 1'b1, 5'd11, 32'h0000_8000, 3'b011, 32'h8001_7FFF, 1, 32'h8001_7FFF);
        do_load(32'h0000_2014, 1'b1, 5'd12, 32'h0000_8000, 3'b010, 32'h8001_7FFF, 1, 32'h0000_7FFF);
        do_load(32'h0000_2018, 1'b1, 5'd13, 32'h0000_8003, 3'b001, 32'h8001_7FFF, 1, 32'hFFFF_FF80);
        do_load(32'h0000_201C, 1'b1, 5'd14, 32'h0000_8001, 3'b101, 32'h8001_7FFF, 1, 32'h0000_007F);
        do_load(32'h0000_2020, 1'b1, 5'd15, 32'h0000_8000, 3'b111, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
        do_load(32'h0000_2024, 1'b0, 5'd16, 32'h0000_8000, 3'b011, 32'h1234_5678, 1, 32'h1234_5678);

        // dest=0 with gr_we: trace PC shows, but no write and no bypass
        exp_q.push_back(mk(32'h0000_3000, 1'b1, 5'd0, 32'h55));
        drive_ms(32'h0000_3000, 1'b1, 5'd0, 32'h55, 3'b000);
        tick();
        ms_valid_i = 1'b0;
        tick();
        idle_check("after_r0");

        // reset during WAIT: no commit, late rvalid ignored
        drive_ms(32'h0000_4000, 1'b1, 5'd20, 32'h0000_8000, 3'b011);
        tick();
        ms_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_wait_allowin", 32'(ws_allowin_o), 32'h0);
        tick();
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_allowin",   32'(ws_allowin_o), 32'h1);
        chk("rst_mid_fwd_valid", 32'(ws_fwd_valid_o), 32'h0);
        tick();
        rst_ni        = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hBAD0_BAD0;
        tick();
        tick();
        data_rvalid_i = 1'b0;
        idle_check("after_rst_wait");
        tick();
        idle_check("after_rst_wait2");

        // drain: all expected commits must have been seen
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("pending_commits", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
